// File: rtl/control_pipeline_pkg.sv
// Shared control-bundle layout for the ID-stage decoder and the control pipeline.
// Group widths, bit positions and the opcode constants both sides agree on.
package control_pipeline_pkg;

  localparam int NB_ALUOP = 6;

  localparam int WB_W        = 2;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_W        = 4;
  localparam int M_JUMP     = 3;
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam int EX_W      = NB_ALUOP + 2;
  localparam int EX_REGDST = NB_ALUOP + 1;
  localparam int EX_ALUSRC = NB_ALUOP;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/control_pipeline_ctrl_stage_reg.sv
// One pipeline register: control bits cleared on bubble,
// register fields always load when enabled.
module ctrl_stage_reg #(
  parameter int CW = 1,
  parameter int FW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] d_ctrl,
  input  logic [FW-1:0] d_fld,
  output logic [CW-1:0] q_ctrl,
  output logic [FW-1:0] q_fld
);

  logic [CW-1:0] ctrl_d, ctrl_q;
  logic [FW-1:0] fld_d, fld_q;

  always_comb begin
    ctrl_d = ctrl_q;
    fld_d  = fld_q;
    if (en) begin
      ctrl_d = clr ? '0 : d_ctrl;
      fld_d  = d_fld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      fld_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      fld_q  <= fld_d;
    end
  end

  assign q_ctrl = ctrl_q;
  assign q_fld  = fld_q;

endmodule

// File: rtl/control_pipeline.sv
// Carries WB/M/EX control groups through ID/EX, EX/MEM, MEM/WB;
// load-use stall, MEM-resolved flush, saturating debug counters.
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                id_RegWrite,
  input  logic                id_MemtoReg,
  input  logic                id_Jump,
  input  logic                id_Branch,
  input  logic                id_MemRead,
  input  logic                id_MemWrite,
  input  logic                id_RegDst,
  input  logic                id_ALUSrc,
  input  logic [NB_ALUOP-1:0] id_ALUOp,
  input  logic [NB_REG-1:0]   id_rs,
  input  logic [NB_REG-1:0]   id_rt,
  input  logic [NB_REG-1:0]   id_rd,
  input  logic                mem_take,
  output logic                stall_out,
  output logic                ex_RegDst,
  output logic                ex_ALUSrc,
  output logic [NB_ALUOP-1:0] ex_ALUOp,
  output logic [NB_REG-1:0]   ex_rt,
  output logic [NB_REG-1:0]   ex_rd,
  output logic                mem_Jump,
  output logic                mem_Branch,
  output logic                mem_MemRead,
  output logic                mem_MemWrite,
  output logic                mem_RegWrite,
  output logic [NB_REG-1:0]   mem_dst,
  output logic                wb_RegWrite,
  output logic                wb_MemtoReg,
  output logic [NB_REG-1:0]   wb_dst,
  output logic [NB_CNT-1:0]   stall_cnt,
  output logic [NB_CNT-1:0]   flush_cnt
);

  localparam int IE_CW = WB_W + M_W + EX_W;
  localparam int EM_CW = WB_W + M_W;

  logic [WB_W-1:0]     id_wb, ex_wb, mem_wb, wb_wb;
  logic [M_W-1:0]      id_m, ex_m, mem_m;
  logic [EX_W-1:0]     id_ex, ex_ex;
  logic [IE_CW-1:0]    ie_ctrl;
  logic [EM_CW-1:0]    em_ctrl;
  logic [2*NB_REG-1:0] ie_fld;
  logic [NB_REG-1:0]   ex_dst;
  logic                hazard;
  logic                stall;

  assign id_wb = {id_RegWrite, id_MemtoReg};
  assign id_m  = {id_Jump, id_Branch, id_MemRead, id_MemWrite};
  assign id_ex = {id_RegDst, id_ALUSrc, id_ALUOp};

  ctrl_stage_reg #(.CW(IE_CW), .FW(2*NB_REG)) u_id_ex (
    .clk    (clk),
    .rst_n  (reset),
    .en     (enable),
    .clr    (stall | mem_take),
    .d_ctrl ({id_wb, id_m, id_ex}),
    .d_fld  ({id_rt, id_rd}),
    .q_ctrl (ie_ctrl),
    .q_fld  (ie_fld)
  );

  assign ex_wb = ie_ctrl[IE_CW-1 -: WB_W];
  assign ex_m  = ie_ctrl[EX_W +: M_W];
  assign ex_ex = ie_ctrl[EX_W-1:0];
  assign ex_rt = ie_fld[2*NB_REG-1 -: NB_REG];
  assign ex_rd = ie_fld[NB_REG-1:0];

  // Destination is resolved as the instruction leaves EX
  assign ex_dst = ex_ex[EX_REGDST] ? ex_rd : ex_rt;

  ctrl_stage_reg #(.CW(EM_CW), .FW(NB_REG)) u_ex_mem (
    .clk    (clk),
    .rst_n  (reset),
    .en     (enable),
    .clr    (mem_take),
    .d_ctrl ({ex_wb, ex_m}),
    .d_fld  (ex_dst),
    .q_ctrl (em_ctrl),
    .q_fld  (mem_dst)
  );

  assign mem_wb = em_ctrl[EM_CW-1 -: WB_W];
  assign mem_m  = em_ctrl[M_W-1:0];

  ctrl_stage_reg #(.CW(WB_W), .FW(NB_REG)) u_mem_wb (
    .clk    (clk),
    .rst_n  (reset),
    .en     (enable),
    .clr    (1'b0),
    .d_ctrl (mem_wb),
    .d_fld  (mem_dst),
    .q_ctrl (wb_wb),
    .q_fld  (wb_dst)
  );

  assign hazard = ex_m[M_MEMREAD] & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));
  // A taken branch kills the dependent instruction anyway
  assign stall  = hazard & ~mem_take;
  assign stall_out = stall;

  assign ex_RegDst    = ex_ex[EX_REGDST];
  assign ex_ALUSrc    = ex_ex[EX_ALUSRC];
  assign ex_ALUOp     = ex_ex[NB_ALUOP-1:0];
  assign mem_Jump     = mem_m[M_JUMP];
  assign mem_Branch   = mem_m[M_BRANCH];
  assign mem_MemRead  = mem_m[M_MEMREAD];
  assign mem_MemWrite = mem_m[M_MEMWRITE];
  assign mem_RegWrite = mem_wb[WB_REGWRITE];
  assign wb_RegWrite  = wb_wb[WB_REGWRITE];
  assign wb_MemtoReg  = wb_wb[WB_MEMTOREG];

  logic [NB_CNT-1:0] stall_cnt_d, stall_cnt_q;
  logic [NB_CNT-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (enable && stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + NB_CNT'(1);
    if (enable && mem_take && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: latency, load-use, flush,
// freeze, mid-stream reset and counter saturation.
module tb_control_pipeline;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        id_RegWrite, id_MemtoReg, id_Jump, id_Branch;
  logic        id_MemRead, id_MemWrite, id_RegDst, id_ALUSrc;
  logic [5:0]  id_ALUOp;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        mem_take;
  logic        stall_out, ex_RegDst, ex_ALUSrc;
  logic [5:0]  ex_ALUOp;
  logic [4:0]  ex_rt, ex_rd;
  logic        mem_Jump, mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite;
  logic [4:0]  mem_dst;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [4:0]  wb_dst;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_pipeline #(.NB_REG(5), .NB_CNT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
    .id_Jump(id_Jump), .id_Branch(id_Branch),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .mem_take(mem_take), .stall_out(stall_out),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_rt(ex_rt), .ex_rd(ex_rd),
    .mem_Jump(mem_Jump), .mem_Branch(mem_Branch),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic drive(input logic rw, input logic mtr, input logic rd_,
                       input logic wr, input logic rdst, input logic asrc,
                       input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_RegWrite = rw;  id_MemtoReg = mtr; id_Jump   = 1'b0;
    id_Branch   = 1'b0; id_MemRead = rd_; id_MemWrite = wr;
    id_RegDst   = rdst; id_ALUSrc  = asrc; id_ALUOp = op;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    nop();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; mem_take = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 6'h3f, 5'd1, 5'd2, 5'd3);
    repeat (3) @(negedge clk);
    n_tests++; if (ex_RegDst !== 1'b0) begin n_fail++; $display("FAIL rst_ex_regdst got %0h want 0", ex_RegDst); end
    n_tests++; if (ex_ALUOp !== 6'h00) begin n_fail++; $display("FAIL rst_ex_aluop got %0h want 0", ex_ALUOp); end
    n_tests++; if (mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL rst_mem_memread got %0h want 0", mem_MemRead); end
    n_tests++; if (wb_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_wb_regwrite got %0h want 0", wb_RegWrite); end
    n_tests++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_counters got %0h/%0h want 0/0", stall_cnt, flush_cnt); end
    nop();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    drive(1, 0, 0, 0, 1, 0, 6'h00, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    n_tests++; if (ex_RegDst !== 1'b1) begin n_fail++; $display("FAIL rt_ex_regdst got %0h want 1", ex_RegDst); end
    n_tests++; if (ex_rd !== 5'd3 || ex_rt !== 5'd2) begin n_fail++; $display("FAIL rt_ex_fields got %0d/%0d want 3/2", ex_rd, ex_rt); end
    nop();
    @(negedge clk);
    n_tests++; if (mem_RegWrite !== 1'b1 || mem_dst !== 5'd3) begin n_fail++; $display("FAIL rt_mem got rw=%0h dst=%0d want 1/3", mem_RegWrite, mem_dst); end
    n_tests++; if (ex_RegDst !== 1'b0) begin n_fail++; $display("FAIL rt_ex_drain got %0h want 0", ex_RegDst); end
    @(negedge clk);
    n_tests++; if (wb_RegWrite !== 1'b1 || wb_dst !== 5'd3) begin n_fail++; $display("FAIL rt_wb got rw=%0h dst=%0d want 1/3", wb_RegWrite, wb_dst); end
    n_tests++; if (mem_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rt_mem_drain got %0h want 0", mem_RegWrite); end
    idle(2);
  endtask

  task automatic test_load_use();
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd5, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 6'h20, 5'd5, 5'd6, 5'd7);
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0h want 1", stall_out); end
    @(negedge clk);
    n_tests++; if (ex_RegDst !== 1'b0 || ex_ALUSrc !== 1'b0 || ex_ALUOp !== 6'h00) begin n_fail++; $display("FAIL lu_bubble got %0h/%0h/%0h want 0/0/0", ex_RegDst, ex_ALUSrc, ex_ALUOp); end
    n_tests++; if (mem_MemRead !== 1'b1 || mem_dst !== 5'd5) begin n_fail++; $display("FAIL lu_mem got rd=%0h dst=%0d want 1/5", mem_MemRead, mem_dst); end
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got %0h want 0", stall_out); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    @(negedge clk);
    n_tests++; if (ex_RegDst !== 1'b1 || ex_ALUOp !== 6'h20) begin n_fail++; $display("FAIL lu_resume got %0h/%0h want 1/20", ex_RegDst, ex_ALUOp); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
    idle(3);
  endtask

  task automatic test_r0();
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd0, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 6'h20, 5'd0, 5'd0, 5'd9);
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %0h want 0", stall_out); end
    idle(3);
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd8, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 6'h20, 5'd1, 5'd8, 5'd9);
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL rt_match_stall got %0h want 1", stall_out); end
    nop();
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rt_nomatch_stall got %0h want 0", stall_out); end
    idle(3);
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL r0_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 1, 0, 6'h00, 5'd1, 5'd2, 5'd9);
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd5, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 6'h20, 5'd5, 5'd6, 5'd7);
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL fl_hazard got %0h want 1", stall_out); end
    mem_take = 1'b1;
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %0h want 0", stall_out); end
    @(negedge clk);
    mem_take = 1'b0;
    nop();
    n_tests++; if (ex_RegDst !== 1'b0 || ex_ALUOp !== 6'h00) begin n_fail++; $display("FAIL fl_idex got %0h/%0h want 0/0", ex_RegDst, ex_ALUOp); end
    n_tests++; if (mem_MemRead !== 1'b0 || mem_RegWrite !== 1'b0) begin n_fail++; $display("FAIL fl_exmem got %0h/%0h want 0/0", mem_MemRead, mem_RegWrite); end
    n_tests++; if (wb_RegWrite !== 1'b1 || wb_dst !== 5'd9) begin n_fail++; $display("FAIL fl_memwb got rw=%0h dst=%0d want 1/9", wb_RegWrite, wb_dst); end
    n_tests++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL fl_counters got %0d/%0d want 1/1", flush_cnt, stall_cnt); end
    idle(3);
  endtask

  task automatic test_freeze();
    drive(1, 0, 0, 0, 1, 0, 6'h00, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 1, 6'h08, 5'd2, 5'd4, 5'd11);
    @(negedge clk);
    enable = 1'b0;
    mem_take = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 6'h3f, 5'd4, 5'd4, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (ex_ALUSrc !== 1'b1 || ex_ALUOp !== 6'h08 || ex_rt !== 5'd4) begin n_fail++; $display("FAIL frz_ex%0d got %0h/%0h/%0d want 1/8/4", i, ex_ALUSrc, ex_ALUOp, ex_rt); end
      n_tests++; if (mem_RegWrite !== 1'b1 || mem_dst !== 5'd3 || mem_MemWrite !== 1'b0) begin n_fail++; $display("FAIL frz_mem%0d got %0h/%0d/%0h want 1/3/0", i, mem_RegWrite, mem_dst, mem_MemWrite); end
      n_tests++; if (wb_RegWrite !== 1'b0 || flush_cnt !== 16'd1) begin n_fail++; $display("FAIL frz_wb%0d got %0h cnt=%0d want 0/1", i, wb_RegWrite, flush_cnt); end
    end
    enable = 1'b1;
    mem_take = 1'b0;
    nop();
    @(negedge clk);
    n_tests++; if (mem_MemWrite !== 1'b1 || mem_RegWrite !== 1'b0 || mem_dst !== 5'd4) begin n_fail++; $display("FAIL frz_res_mem got %0h/%0h/%0d want 1/0/4", mem_MemWrite, mem_RegWrite, mem_dst); end
    n_tests++; if (wb_RegWrite !== 1'b1 || wb_dst !== 5'd3) begin n_fail++; $display("FAIL frz_res_wb got %0h/%0d want 1/3", wb_RegWrite, wb_dst); end
    n_tests++; if (ex_ALUSrc !== 1'b0) begin n_fail++; $display("FAIL frz_res_ex got %0h want 0", ex_ALUSrc); end
  endtask

  task automatic test_reset_midstream();
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd5, 5'd0);
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (ex_ALUSrc !== 1'b0 || ex_rt !== 5'd0 || mem_MemWrite !== 1'b0 || wb_RegWrite !== 1'b0) begin n_fail++; $display("FAIL mrst_regs got %0h/%0d/%0h/%0h want 0", ex_ALUSrc, ex_rt, mem_MemWrite, wb_RegWrite); end
    n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    reset = 1'b1;
    enable = 1'b1;
    idle(2);
  endtask

  task automatic test_saturate();
    drive(1, 1, 1, 0, 0, 1, 6'h00, 5'd1, 5'd5, 5'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 6'h20, 5'd5, 5'd6, 5'd7);
    force dut.stall_cnt_q = 16'hffff;
    #1;
    release dut.stall_cnt_q;
    #1;
    n_tests++; if (stall_out !== 1'b1 || stall_cnt !== 16'hffff) begin n_fail++; $display("FAIL sat_setup got %0h/%0h want 1/ffff", stall_out, stall_cnt); end
    @(negedge clk);
    n_tests++; if (stall_cnt !== 16'hffff) begin n_fail++; $display("FAIL sat_hold got %0h want ffff", stall_cnt); end
    idle(2);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; mem_take = 1'b0;
    nop();
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_use();
    test_r0();
    test_flush();
    test_freeze();
    test_reset_midstream();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
